// File: rtl/scan_sel_sequencer.sv
// Channel-select sequencer feeding a 3-to-8 decoder: walks the enabled channels
// in ascending circular order, holding each one for a programmable dwell time.
module scan_sel_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               in_clk,
  input  logic               in_rst_n,
  input  logic               in_start,
  input  logic               in_stop,
  input  logic               in_single,
  input  logic [7:0]         in_mask,
  input  logic [DWELL_W-1:0] in_dwell,
  output logic [2:0]         out_sel,
  output logic               out_valid,
  output logic               out_busy,
  output logic               out_wrap,
  output logic               out_done,
  output logic               out_state
);

  // Handshake: in_start is a one-cycle request honoured only while idle with a
  // non-empty mask; in_stop always wins. Outputs are registered, one cycle later.
  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t             state;
  logic [7:0]         mask_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               single_q;
  logic [DWELL_W-1:0] cnt;

  logic [DWELL_W-1:0] dwell_eff;
  logic [2:0]         next_ch;
  logic [2:0]         first_ch;
  logic               is_wrap;

  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Circular priority search starting one past the current channel; k = 8
  // lands back on the current channel when it is the only one enabled.
  function automatic logic [2:0] next_set(input logic [7:0] m, input logic [2:0] cur);
    logic [2:0] r;
    logic       found;
    logic [2:0] idx;
    r = cur;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = cur + 3'(k);
      if (!found && m[idx]) begin
        r = idx;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    dwell_eff = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
    next_ch   = next_set(mask_q, out_sel);
    first_ch  = lowest_set(in_mask);
    is_wrap   = (next_ch <= out_sel);
  end

  assign out_state = state;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state     <= IDLE;
      out_sel   <= 3'd0;
      out_valid <= 1'b0;
      out_busy  <= 1'b0;
      out_wrap  <= 1'b0;
      out_done  <= 1'b0;
      mask_q    <= 8'd0;
      dwell_q   <= '0;
      single_q  <= 1'b0;
      cnt       <= '0;
    end else begin
      out_wrap <= 1'b0;
      out_done <= 1'b0;
      if (in_stop) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        out_busy  <= 1'b0;
        cnt       <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (in_start && (in_mask != 8'd0)) begin
              mask_q    <= in_mask;
              dwell_q   <= in_dwell;
              single_q  <= in_single;
              out_sel   <= first_ch;
              out_valid <= 1'b1;
              out_busy  <= 1'b1;
              cnt       <= DWELL_W'(1);
              state     <= SCAN;
            end
          end
          SCAN: begin
            if (cnt < dwell_eff) begin
              cnt <= cnt + DWELL_W'(1);
            end else if (is_wrap && single_q) begin
              // Pass complete: keep the last channel visible on out_sel.
              state     <= IDLE;
              out_valid <= 1'b0;
              out_busy  <= 1'b0;
              out_done  <= 1'b1;
              cnt       <= '0;
            end else begin
              out_sel  <= next_ch;
              cnt      <= DWELL_W'(1);
              out_wrap <= is_wrap;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scan_sel_sequencer.sv
// Directed bench for scan_sel_sequencer: per-scenario tasks with hand-computed
// expected {sel, valid, busy, wrap, done} vectors checked on the falling edge.
module tb_scan_sel_sequencer;

  logic       in_clk;
  logic       in_rst_n;
  logic       in_start;
  logic       in_stop;
  logic       in_single;
  logic [7:0] in_mask;
  logic [7:0] in_dwell;
  logic [2:0] out_sel;
  logic       out_valid;
  logic       out_busy;
  logic       out_wrap;
  logic       out_done;
  logic       out_state;

  int n_cmp;
  int n_err;

  scan_sel_sequencer #(.DWELL_W(8)) dut (
    .in_clk    (in_clk),
    .in_rst_n  (in_rst_n),
    .in_start  (in_start),
    .in_stop   (in_stop),
    .in_single (in_single),
    .in_mask   (in_mask),
    .in_dwell  (in_dwell),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_busy  (out_busy),
    .out_wrap  (out_wrap),
    .out_done  (out_done),
    .out_state (out_state)
  );

  // clock / reset
  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  logic [6:0] obs;
  assign obs = {out_sel, out_valid, out_busy, out_wrap, out_done};

  task automatic tick();
    @(posedge in_clk);
    @(negedge in_clk);
  endtask

  task automatic do_start(input logic [7:0] m, input logic [7:0] d, input logic s);
    in_mask = m; in_dwell = d; in_single = s; in_start = 1'b1;
    tick();
    in_start = 1'b0;
  endtask

  task automatic do_stop();
    in_stop = 1'b1;
    tick();
    in_stop = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] exp;
    in_rst_n = 1'b0; in_start = 1'b0; in_stop = 1'b0;
    in_single = 1'b0; in_mask = 8'd0; in_dwell = 8'd0;
    tick(); tick();
    n_cmp++;
    if (obs !== 7'd0 || out_state !== 1'b0) begin
      n_err++; $display("FAIL reset_power_up got %b/%b exp 0000000/0", obs, out_state);
    end
    in_rst_n = 1'b1;
    tick();
    do_start(8'hFF, 8'd4, 1'b0);
    tick(); tick(); tick(); tick(); tick();
    exp = {3'd1, 4'b1100};
    n_cmp++;
    if (obs !== exp) begin
      n_err++; $display("FAIL reset_pre_scan got %b exp %b", obs, exp);
    end
    #2 in_rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 7'd0 || out_state !== 1'b0) begin
      n_err++; $display("FAIL reset_async got %b/%b exp 0000000/0", obs, out_state);
    end
    @(negedge in_clk);
    in_rst_n = 1'b1;
    tick(); tick(); tick();
    n_cmp++;
    if (obs !== 7'd0) begin
      n_err++; $display("FAIL reset_idle_after got %b exp 0000000", obs);
    end
  endtask

  task automatic test_full_single();
    logic [6:0] exp;
    do_start(8'hFF, 8'd3, 1'b1);
    for (int ch = 0; ch < 8; ch++) begin
      for (int k = 0; k < 3; k++) begin
        exp = {3'(ch), 4'b1100};
        n_cmp++;
        if (obs !== exp) begin
          n_err++; $display("FAIL full_single ch%0d cyc%0d got %b exp %b", ch, k, obs, exp);
        end
        tick();
      end
    end
    exp = {3'd7, 4'b0001};
    n_cmp++;
    if (obs !== exp) begin
      n_err++; $display("FAIL full_single_done got %b exp %b", obs, exp);
    end
    // start on the cycle right after done is visible
    do_start(8'h81, 8'd2, 1'b1);
    exp = {3'd0, 4'b1100};
    n_cmp++;
    if (obs !== exp) begin
      n_err++; $display("FAIL start_after_done got %b exp %b", obs, exp);
    end
    do_stop();
    exp = {3'd0, 4'b0000};
    n_cmp++;
    if (obs !== exp) begin
      n_err++; $display("FAIL start_after_done_stop got %b exp %b", obs, exp);
    end
  endtask

  task automatic test_sparse_cont();
    logic [6:0] exp;
    logic [2:0] seq [7];
    seq = '{3'd2, 3'd5, 3'd7, 3'd2, 3'd5, 3'd7, 3'd2};
    do_start(8'b1010_0100, 8'd2, 1'b0);
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < 2; k++) begin
        exp = {seq[i], 2'b11, (i > 0 && seq[i] == 3'd2 && k == 0), 1'b0};
        n_cmp++;
        if (obs !== exp) begin
          n_err++; $display("FAIL sparse_cont step%0d cyc%0d got %b exp %b", i, k, obs, exp);
        end
        tick();
      end
    end
    do_stop();
  endtask

  task automatic test_single_dwell0();
    logic [6:0] exp;
    do_start(8'h10, 8'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      exp = {3'd4, 2'b11, (i > 0), 1'b0};
      n_cmp++;
      if (obs !== exp) begin
        n_err++; $display("FAIL single_dwell0 cyc%0d got %b exp %b", i, obs, exp);
      end
      tick();
    end
    do_stop();
    exp = {3'd4, 4'b0000};
    n_cmp++;
    if (obs !== exp) begin
      n_err++; $display("FAIL single_dwell0_stop got %b exp %b", obs, exp);
    end
  endtask

  task automatic test_stop_conflicts();
    logic [6:0] exp;
    // start together with stop: stays idle
    in_stop = 1'b1;
    do_start(8'h01, 8'd2, 1'b0);
    in_stop = 1'b0;
    exp = {3'd4, 4'b0000};
    n_cmp++;
    if (obs !== exp || out_state !== 1'b0) begin
      n_err++; $display("FAIL start_with_stop got %b exp %b", obs, exp);
    end
    // stop mid-dwell on channel 3
    do_start(8'h08, 8'd5, 1'b1);
    tick();
    exp = {3'd3, 4'b1100};
    n_cmp++;
    if (obs !== exp) begin
      n_err++; $display("FAIL stop_mid_pre got %b exp %b", obs, exp);
    end
    do_stop();
    exp = {3'd3, 4'b0000};
    n_cmp++;
    if (obs !== exp) begin
      n_err++; $display("FAIL stop_mid_dwell got %b exp %b", obs, exp);
    end
    tick();
    n_cmp++;
    if (obs !== exp) begin
      n_err++; $display("FAIL stop_no_done got %b exp %b", obs, exp);
    end
    // start during scan is ignored
    do_start(8'hFF, 8'd2, 1'b0);
    tick();
    do_start(8'h80, 8'd9, 1'b1);
    exp = {3'd1, 4'b1100};
    n_cmp++;
    if (obs !== exp) begin
      n_err++; $display("FAIL start_in_scan_a got %b exp %b", obs, exp);
    end
    tick(); tick();
    exp = {3'd2, 4'b1100};
    n_cmp++;
    if (obs !== exp) begin
      n_err++; $display("FAIL start_in_scan_b got %b exp %b", obs, exp);
    end
    do_stop();
    // start with empty mask is ignored
    do_start(8'h00, 8'd1, 1'b0);
    tick();
    exp = {3'd2, 4'b0000};
    n_cmp++;
    if (obs !== exp || out_state !== 1'b0) begin
      n_err++; $display("FAIL start_mask0 got %b exp %b", obs, exp);
    end
  endtask

  task automatic test_latch_maxdwell();
    logic [6:0] exp;
    logic [2:0] seq [4];
    int         run0;
    int         run1;
    seq = '{3'd1, 3'd5, 3'd1, 3'd5};
    do_start(8'h22, 8'd1, 1'b0);
    in_mask = 8'hFF; in_dwell = 8'd7; in_single = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = {seq[i], 2'b11, (i == 2), 1'b0};
      n_cmp++;
      if (obs !== exp) begin
        n_err++; $display("FAIL latch step%0d got %b exp %b", i, obs, exp);
      end
      tick();
    end
    do_stop();
    do_start(8'h03, 8'd255, 1'b1);
    run0 = 0; run1 = 0;
    for (int c = 0; c < 520; c++) begin
      if (out_valid === 1'b1 && out_sel === 3'd0) run0++;
      if (out_valid === 1'b1 && out_sel === 3'd1) run1++;
      if (out_done === 1'b1) break;
      tick();
    end
    n_cmp++;
    if (run0 !== 255) begin
      n_err++; $display("FAIL maxdwell_ch0 got %0d exp 255", run0);
    end
    n_cmp++;
    if (run1 !== 255) begin
      n_err++; $display("FAIL maxdwell_ch1 got %0d exp 255", run1);
    end
    exp = {3'd1, 4'b0001};
    n_cmp++;
    if (obs !== exp) begin
      n_err++; $display("FAIL maxdwell_done got %b exp %b", obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_full_single();
    test_sparse_cont();
    test_single_dwell0();
    test_stop_conflicts();
    test_latch_maxdwell();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
